// File: rtl/fifo_sched.sv
// rtl/fifo_sched.sv - round-robin write scheduler and read fetch FSM around a shared FIFO
//
// Purpose:
//   Several requesters share one FIFO write port through a round-robin
//   arbiter. A three-state fetch FSM drains the FIFO one word at a time
//   towards a valid/ready consumer.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   req, req_data   per-requester write request and word (slice i = requester i)
//   gnt             one-hot grant; word i is consumed in the cycle gnt[i]=1
//   fifo_wren/wdata FIFO write port
//   fifo_rden       FIFO read enable; fifo_rdata is valid the following cycle
//   fifo_full/empty FIFO status flags
//   out_valid/data  consumer side, accepted on out_valid & out_ready
//   wr_count        free-running count of FIFO writes (wraps at 2^16)

module fifo_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wren,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic                          fifo_rden,
  input  logic [DATA_WIDTH-1:0]         fifo_rdata,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic [15:0]                   wr_count
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW:0]   NREQ = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} rd_state_t;

  rd_state_t       state_q, state_d;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   sel;
  logic [PW:0]     cand;
  logic            found;
  logic            rden_c;
  logic            wr_block;

  // Round-robin search: walk NUM_REQ positions starting at rr_ptr, wrapping
  // by subtraction so non-power-of-two requester counts stay in range.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        sel   = cand[PW-1:0];
      end
    end
  end

  // The FIFO drops a write that coincides with a read, so no grant is
  // issued in a read cycle; the requester simply retries later.
  assign wr_block = rst | fifo_full | fifo_rden;

  always_comb begin
    gnt = '0;
    if (found && !wr_block) gnt[sel] = 1'b1;
  end

  assign fifo_wren = |gnt;

  // gnt is one-hot, so OR-ing the gated slices acts as the data mux.
  always_comb begin
    fifo_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) fifo_wdata = fifo_wdata | req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Read-side FSM: IDLE issues the read, FETCH captures the registered
  // FIFO data, HOLD presents it until the consumer takes it.
  always_comb begin
    state_d = state_q;
    rden_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          rden_c  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = HOLD;
      HOLD:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign fifo_rden = rden_c & ~rst;
  assign out_valid = (state_q == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      out_data <= '0;
      rr_ptr   <= '0;
      wr_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH) out_data <= fifo_rdata;
      if (fifo_wren) begin
        rr_ptr   <= (sel == LAST) ? '0 : sel + PW'(1);
        wr_count <= wr_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/fifo_sched.md
FIFO_SCHED -- requirements
Module: fifo_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width matching the shared FIFO.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester write request.
REQ-006 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  requester i word at slice i.
REQ-007 SHALL have port gnt  output  NUM_REQ  one-hot write grant; word i consumed in the cycle gnt[i]=1.
REQ-008 SHALL have port fifo_wren  output  1  FIFO write enable.
REQ-009 SHALL have port fifo_wdata  output  DATA_WIDTH  FIFO write data.
REQ-010 SHALL have port fifo_rden  output  1  FIFO read enable.
REQ-011 SHALL have port fifo_rdata  input  DATA_WIDTH  FIFO registered read data, valid the cycle after an accepted rden.
REQ-012 SHALL have port fifo_full  input  1  FIFO full flag.
REQ-013 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-014 SHALL have port out_valid  output  1  consumer data valid.
REQ-015 SHALL have port out_data  output  DATA_WIDTH  consumer data.
REQ-016 SHALL have port out_ready  input  1  consumer accepts when out_valid & out_ready.
REQ-017 SHALL have port wr_count  output  16  total words written to FIFO, wraps at 2^16.

Function
REQ-018 Write arbitration SHALL be round-robin over req, starting search at pointer rr_ptr, combinational within the cycle.
REQ-019 gnt SHALL be all-zero when fifo_full=1 or fifo_rden=1 in the same cycle (FIFO gives read precedence and drops a simultaneous write).
REQ-020 Otherwise gnt SHALL select the first asserted req[i] at or after rr_ptr modulo NUM_REQ; at most one bit set.
REQ-021 fifo_wren SHALL equal |gnt; fifo_wdata SHALL equal req_data slice of the granted index, else zero.
REQ-022 On a grant to index i, rr_ptr SHALL become (i+1) mod NUM_REQ next cycle; with no grant rr_ptr SHALL hold.
REQ-023 wr_count SHALL increment by 1 on every cycle with fifo_wren=1, wrapping 0xFFFF -> 0x0000.
REQ-024 Read side SHALL be an FSM with states IDLE, FETCH, HOLD.
REQ-025 IDLE: if fifo_empty=0, assert fifo_rden (combinational) and go FETCH; else stay IDLE.
REQ-026 FETCH: capture fifo_rdata into out_data, set out_valid=1, go HOLD; fifo_rden=0.
REQ-027 HOLD: out_valid=1, out_data stable; on out_ready=1 clear out_valid and go IDLE (next fetch no earlier than following cycle).
REQ-028 fifo_rden SHALL never assert outside IDLE or while fifo_empty=1.
REQ-029 Read throughput SHALL be at most one word per 3 cycles; minimum latency from fifo_empty falling to out_valid rising is 2 cycles.
REQ-030 A requester whose req drops without grant SHALL lose nothing; no state records ungranted requests.

Reset
REQ-031 With rst=1 at a clock edge: rr_ptr=0, FSM=IDLE, out_valid=0, out_data=0, wr_count=0.
REQ-032 While rst=1, gnt, fifo_wren and fifo_rden SHALL be 0 regardless of inputs.
REQ-033 Reset mid-transfer (FETCH or HOLD) SHALL discard the pending word; no replay after rst deasserts.

Verification
REQ-034 req=4'b1111, FIFO empty/non-full, 4 cycles -> gnt sequence 0001,0010,0100,1000; wr_count=4.
REQ-035 rr_ptr=2, req=4'b0011 -> gnt=0001 then rr_ptr=1; next cycle req=0011 -> gnt=0010.
REQ-036 fifo_full=1 with req=1111 -> gnt=0, fifo_wren=0, rr_ptr and wr_count unchanged.
REQ-037 FIFO holds 0xA5A5_0001, out_ready=1 -> rden cycle 0, out_valid=1 with out_data=0xA5A5_0001 from cycle 2, cleared cycle 3; same-cycle req gets gnt=0 only in cycle 0.
REQ-038 out_ready=0 for 10 cycles in HOLD -> out_data stable, fifo_rden=0 throughout; writes continue granting.
REQ-039 wr_count preloaded to 0xFFFF via 65535 writes, one more write -> wr_count=0x0000; rst pulse in HOLD -> out_valid=0 next cycle.
